// File: rtl/mdc_pkg.sv
// Shared encodings and default timings for the drink sequencer.
package mdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_HEAT  = 3'd2,
        ST_GRIND = 3'd3,
        ST_BREW  = 3'd4,
        ST_DRIP  = 3'd5,
        ST_DONE  = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_AGUA  = 2'b01;
    localparam logic [1:0] ERR_CAFE  = 2'b10;
    localparam logic [1:0] ERR_CALOR = 2'b11;

    localparam int T_MOLER_DEF     = 4;
    localparam int T_AGUA_P_DEF    = 6;
    localparam int T_AGUA_G_DEF    = 10;
    localparam int T_GOTEO_DEF     = 3;
    localparam int T_CALOR_MAX_DEF = 8;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/mdc_temporizador.sv
// Up-counter with synchronous clear; fin_o flags when the count hits the terminal value.
module mdc_temporizador #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             fin_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign fin_o = (cnt_q == term_i);

endmodule

// File: rtl/mdc_secuenciador_dispensa.sv
// Drink-cycle sequencer: supply check, heat, grind, brew, drip, with sticky fault reporting.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | one-cycle supply check
// HEAT  | heater on until temp_ok or heat timeout
// GRIND | grinder on for T_MOLER cycles
// BREW  | pump and heater on for the cup-size time
// DRIP  | all actuators off for T_GOTEO cycles
// DONE  | one-cycle completion pulse
// FAULT | fault latched until err_ack or abortar
module mdc_secuenciador_dispensa
    import mdc_pkg::*;
#(
    parameter int T_MOLER     = T_MOLER_DEF,
    parameter int T_AGUA_P    = T_AGUA_P_DEF,
    parameter int T_AGUA_G    = T_AGUA_G_DEF,
    parameter int T_GOTEO     = T_GOTEO_DEF,
    parameter int T_CALOR_MAX = T_CALOR_MAX_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       tamano_i,
    input  logic       hay_agua_i,
    input  logic       hay_cafe_i,
    input  logic       temp_ok_i,
    input  logic       abortar_i,
    input  logic       err_ack_i,
    output logic       heater_o,
    output logic       grinder_o,
    output logic       pump_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [1:0] err_code_o,
    output logic [2:0] estado_o
);

    localparam logic [CNT_W-1:0] TERM_MOLER  = CNT_W'(T_MOLER - 1);
    localparam logic [CNT_W-1:0] TERM_AGUA_P = CNT_W'(T_AGUA_P - 1);
    localparam logic [CNT_W-1:0] TERM_AGUA_G = CNT_W'(T_AGUA_G - 1);
    localparam logic [CNT_W-1:0] TERM_GOTEO  = CNT_W'(T_GOTEO - 1);
    localparam logic [CNT_W-1:0] TERM_CALOR  = CNT_W'(T_CALOR_MAX - 1);

    state_t           state_q, state_d;
    logic             tamano_q, tamano_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] term;
    logic             fin;
    logic             tmr_clr;

    // The timer restarts from zero whenever the FSM changes state.
    assign tmr_clr = (state_d != state_q);

    mdc_temporizador #(
        .CNT_W (CNT_W)
    ) u_temporizador (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (tmr_clr),
        .term_i (term),
        .fin_o  (fin)
    );

    always_comb begin
        case (state_q)
            ST_HEAT:  term = TERM_CALOR;
            ST_GRIND: term = TERM_MOLER;
            ST_BREW:  term = tamano_q ? TERM_AGUA_G : TERM_AGUA_P;
            ST_DRIP:  term = TERM_GOTEO;
            default:  term = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tamano_q   <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            tamano_q   <= tamano_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tamano_d   = tamano_q;
        err_code_d = err_code_q;
        // Abort returns to IDLE from anywhere and also releases a latched fault.
        if (abortar_i) begin
            state_d    = ST_IDLE;
            err_code_d = ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        tamano_d = tamano_i;
                        state_d  = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!hay_agua_i) begin
                        state_d    = ST_FAULT;
                        err_code_d = ERR_AGUA;
                    end else if (!hay_cafe_i) begin
                        state_d    = ST_FAULT;
                        err_code_d = ERR_CAFE;
                    end else begin
                        state_d = ST_HEAT;
                    end
                end
                ST_HEAT: begin
                    if (temp_ok_i) begin
                        state_d = ST_GRIND;
                    end else if (fin) begin
                        state_d    = ST_FAULT;
                        err_code_d = ERR_CALOR;
                    end
                end
                ST_GRIND: begin
                    if (!hay_cafe_i) begin
                        state_d    = ST_FAULT;
                        err_code_d = ERR_CAFE;
                    end else if (fin) begin
                        state_d = ST_BREW;
                    end
                end
                ST_BREW: begin
                    if (!hay_agua_i) begin
                        state_d    = ST_FAULT;
                        err_code_d = ERR_AGUA;
                    end else if (fin) begin
                        state_d = ST_DRIP;
                    end
                end
                ST_DRIP: begin
                    if (fin) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    if (err_ack_i) begin
                        state_d    = ST_IDLE;
                        err_code_d = ERR_NONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        heater_o  = 1'b0;
        grinder_o = 1'b0;
        pump_o    = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        error_o   = 1'b0;
        case (state_q)
            ST_IDLE:  busy_o = 1'b0;
            ST_HEAT:  heater_o = 1'b1;
            ST_GRIND: grinder_o = 1'b1;
            ST_BREW: begin
                heater_o = 1'b1;
                pump_o   = 1'b1;
            end
            ST_DONE:  done_o = 1'b1;
            ST_FAULT: begin
                busy_o  = 1'b0;
                error_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_code_o = err_code_q;
    assign estado_o   = state_q;

endmodule
